bus_mux_reg: RTL
================

# bus_mux_reg

Registered, parametrised datapath bus multiplexer for the simple processor. It selects one of DIN, G or NREG general registers onto the shared bus and captures the result in an output register, giving a clean one-cycle bus. It holds the last value when nothing is selected or the bus is stalled, and flags illegal multi-hot register selects. It replaces the combinational bus mux between the register file/G and the ALU/register inputs.

## Interface
- W, 16: bus and register width.
- NREG, 8: number of general registers R0..R(NREG-1); legal range 2..16.
- SW, $clog2(NREG+2): width of the source code.

- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- DIN  in  W  external data input.
- RSaida  in  NREG*W  register outputs, flattened; Rk occupies [k*W +: W].
- GSaida  in  W  G register output.
- ROut  in  NREG  one-hot register select; bit k selects Rk.
- GOut  in  1  select G.
- DINOut  in  1  select DIN.
- Hold  in  1  stall; freezes all outputs.
- ClrErro  in  1  clears SelErro and ErroCount.
- MuxSaida  out  W  registered bus value.
- BusValid  out  1  high for the cycle after a legal source was captured.
- BusSrc  out  SW  code of the source currently on MuxSaida: k = Rk, NREG = G, NREG+1 = DIN.
- SelErro  out  1  sticky illegal-select flag.
- ErroCount  out  8  saturating count of illegal-select cycles.

## Operation
- Priority: DINOut > GOut > ROut.
- Each non-Hold cycle, the block evaluates the winning source. A legal source updates MuxSaida and BusSrc and sets BusValid=1.
- No source selected (all selects 0): MuxSaida and BusSrc hold, BusValid=0. No latch is allowed.
- Illegal select: DINOut=0, GOut=0 and ROut has more than one bit set. With checking compiled in, MuxSaida and BusSrc hold, BusValid=0, SelErro sets, and ErroCount increments, saturating at 255.
- DINOut or GOut asserted together with a multi-hot ROut is not an error; priority resolves it.
- Hold=1: every output register keeps its value, BusValid included, and no error is recorded.
- ClrErro=1: SelErro and ErroCount go to 0 on the next edge, unless an illegal select occurs in the same cycle. In that case SelErro=1 and ErroCount=1: the new error wins.
- Hold and ClrErro in the same cycle: the clear applies and the bus stays frozen.

## Timing
- Latency: one cycle from select/data to MuxSaida.
- Data inputs are sampled at the same edge as the selects; no combinational path from input to output.
- Reset, asynchronous, applies immediately, including mid-transfer: MuxSaida=0, BusSrc=0, BusValid=0, SelErro=0, ErroCount=0.
- After Reset deasserts, the first legal select is visible one edge later.
- Back-to-back selects give a new value every cycle; BusValid stays high throughout.

## Configuration
- BUS_MUX_ONEHOT_CHECK_EN defined: multi-hot detection, SelErro and ErroCount behave as in Operation.
- BUS_MUX_ONEHOT_CHECK_EN undefined: SelErro and ErroCount are constant 0. A multi-hot ROut is resolved as lowest-index-wins and treated as legal: update, BusValid=1.

## Structure
- Package bus_mux_pkg holds:
  - source-code constants SRC_G(NREG)=NREG and SRC_DIN(NREG)=NREG+1;
  - the error-counter width (8);
  - the saturation value (255).
- One sub-module, onehot_enc: NREG-bit select in, then index (lowest set bit), any-set flag and multi-hot flag out; it is purely combinational.
- bus_mux_reg holds the priority logic and all registers.

## Test plan
- Reset, then ROut=8'b0000_0100 with R2=16'h1234. Next edge: MuxSaida=16'h1234, BusSrc=2, BusValid=1.
- DINOut=1, GOut=1, ROut=8'h01, DIN=16'hBEEF. Result: MuxSaida=16'hBEEF, BusSrc=9 (NREG=8); the cycle after, GOut only with G=16'h0F0F, result MuxSaida=16'h0F0F, BusSrc=8.
- All selects 0 after a capture of 16'hAAAA. Result: MuxSaida stays 16'hAAAA, BusValid=0.
- Check enabled, ROut=8'h03 for 3 cycles. Result: MuxSaida unchanged, SelErro=1, ErroCount=3.
  - Then ClrErro with ROut=8'h03 again: ErroCount=1, SelErro=1.
  - Then 300 illegal cycles: ErroCount=255.
- Hold=1 while ROut changes each cycle. Result: all outputs frozen.
  - Then Reset pulse mid-hold: all outputs 0 immediately, without a clock edge.
- Check disabled, ROut=8'h06 with R1=16'h0001, R2=16'h0002. Result: MuxSaida=16'h0001, BusSrc=1, BusValid=1, SelErro=0.

Source files
------------

// File: rtl/bus_mux_pkg.sv
// -----------------------------------------------------------------------------
// bus_mux_pkg
// Shared constants for the registered processor bus multiplexer.
//   src_g(nreg)   : BusSrc code used when G drives the bus
//   src_din(nreg) : BusSrc code used when DIN drives the bus
//   ERR_W         : width of the illegal-select counter
//   ERR_SAT       : value at which the illegal-select counter saturates
// -----------------------------------------------------------------------------
package bus_mux_pkg;

   localparam int ERR_W = 8;
   localparam logic [ERR_W-1:0] ERR_SAT = 8'd255;

   // Register sources occupy codes 0..nreg-1; G and DIN follow directly.
   function automatic int src_g(input int nreg);
      return nreg;
   endfunction

   function automatic int src_din(input int nreg);
      return nreg + 1;
   endfunction

endpackage

// File: rtl/bus_mux_reg_onehot_enc.sv
// -----------------------------------------------------------------------------
// onehot_enc
// Purely combinational select encoder.
//   sel   in  N          one-hot (ideally) select vector
//   idx   out clog2(N)   index of the lowest set bit (0 when none set)
//   any   out 1          at least one bit set
//   multi out 1          more than one bit set
// -----------------------------------------------------------------------------
module onehot_enc #(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  sel,
   output logic [IW-1:0] idx,
   output logic          any,
   output logic          multi
);

   // NOTE: every variable written here gets a default before the loop, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      idx = '0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (sel[i]) idx = IW'(i);
      end
   end

   assign any   = |sel;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi = |(sel & (sel - N'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// -----------------------------------------------------------------------------
// bus_mux_reg
// Registered bus multiplexer: picks DIN, G or one general register (priority
// DIN > G > R) and captures it in an output register, giving a clean one-cycle
// bus. Holds the last value when nothing is selected or when stalled.
//
// Optional feature macro: BUS_MUX_ONEHOT_CHECK_EN
//   defined   : multi-hot ROut (without DIN/G) is illegal; bus holds, SelErro
//               sets and ErroCount counts (saturating).
//   undefined : multi-hot ROut resolves lowest-index-wins; SelErro and
//               ErroCount are constant 0.
//
// Ports
//   Clock     in  1        rising-edge clock
//   Reset     in  1        asynchronous active-high reset
//   DIN       in  W        external data
//   RSaida    in  NREG*W   register outputs, Rk at [k*W +: W]
//   GSaida    in  W        G register output
//   ROut      in  NREG     register select, bit k selects Rk
//   GOut      in  1        select G
//   DINOut    in  1        select DIN
//   Hold      in  1        stall, freezes all outputs
//   ClrErro   in  1        clears SelErro and ErroCount
//   MuxSaida  out W        registered bus value
//   BusValid  out 1        a legal source was captured on the last edge
//   BusSrc    out SW       source code of MuxSaida (k, NREG=G, NREG+1=DIN)
//   SelErro   out 1        sticky illegal-select flag
//   ErroCount out 8        saturating illegal-select cycle count
// -----------------------------------------------------------------------------
module bus_mux_reg
   import bus_mux_pkg::*;
#(
   parameter int W    = 16,
   parameter int NREG = 8,
   parameter int SW   = $clog2(NREG + 2)
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [W-1:0]      DIN,
   input  logic [NREG*W-1:0] RSaida,
   input  logic [W-1:0]      GSaida,
   input  logic [NREG-1:0]   ROut,
   input  logic              GOut,
   input  logic              DINOut,
   input  logic              Hold,
   input  logic              ClrErro,
   output logic [W-1:0]      MuxSaida,
   output logic              BusValid,
   output logic [SW-1:0]     BusSrc,
   output logic              SelErro,
   output logic [ERR_W-1:0]  ErroCount
);

   localparam int IW = $clog2(NREG);

   logic [IW-1:0] r_idx;
   logic          r_any;
   logic          r_multi;

   onehot_enc #(.N(NREG), .IW(IW)) u_enc (
      .sel   (ROut),
      .idx   (r_idx),
      .any   (r_any),
      .multi (r_multi)
   );

   logic          legal;
   logic          illegal;
   logic [W-1:0]  nxt_data;
   logic [SW-1:0] nxt_src;

   always_comb begin
      legal    = 1'b0;
      illegal  = 1'b0;
      nxt_data = MuxSaida;
      nxt_src  = BusSrc;
      if (DINOut) begin
         legal    = 1'b1;
         nxt_data = DIN;
         nxt_src  = SW'(src_din(NREG));
      end else if (GOut) begin
         legal    = 1'b1;
         nxt_data = GSaida;
         nxt_src  = SW'(src_g(NREG));
      end else if (r_any) begin
`ifdef BUS_MUX_ONEHOT_CHECK_EN
         illegal = r_multi;
`endif
         if (!illegal) begin
            legal    = 1'b1;
            nxt_data = RSaida[r_idx*W +: W];
            nxt_src  = SW'(r_idx);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         MuxSaida <= '0;
         BusSrc   <= '0;
         BusValid <= 1'b0;
      end else if (!Hold) begin
         BusValid <= legal;
         if (legal) begin
            MuxSaida <= nxt_data;
            BusSrc   <= nxt_src;
         end
      end
   end

`ifdef BUS_MUX_ONEHOT_CHECK_EN
   logic unused_nothing;
   assign unused_nothing = 1'b0;

   // A stalled cycle never records an error; the clear still applies.
   logic err_now;
   assign err_now = illegal && !Hold;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         SelErro   <= 1'b0;
         ErroCount <= '0;
      end else if (ClrErro) begin
         // A new error in the clearing cycle wins over the clear.
         SelErro   <= err_now;
         ErroCount <= err_now ? ERR_W'(1) : '0;
      end else if (err_now) begin
         SelErro <= 1'b1;
         if (ErroCount != ERR_SAT) ErroCount <= ErroCount + ERR_W'(1);
      end
   end
`else
   logic unused_chk;
   assign unused_chk = r_multi ^ ClrErro ^ illegal;

   assign SelErro   = 1'b0;
   assign ErroCount = '0;
`endif

endmodule
